// File: rtl/sha_schedule_sequencer_if.sv
// Block-in / schedule-word-out handshake bundle for the SHA-256 schedule sequencer.
interface sha_schedule_sequencer_if;
  logic                  blk_valid_i;
  logic                  blk_ready_o;
  logic [15:0][31:0]     blk_i;
  logic                  w_valid_o;
  logic                  w_ready_i;
  logic [31:0]           w_o;
  logic [5:0]            t_o;
  logic                  last_o;
  logic                  busy_o;

  modport master (
    output blk_valid_i, blk_i, w_ready_i,
    input  blk_ready_o, w_valid_o, w_o, t_o, last_o, busy_o
  );

  modport slave (
    input  blk_valid_i, blk_i, w_ready_i,
    output blk_ready_o, w_valid_o, w_o, t_o, last_o, busy_o
  );
endinterface

// File: rtl/sha_schedule_sequencer.sv
// Iterative SHA-256 message-schedule sequencer: loads one 16-word block and
// streams W_0..W_63 using a 16-word sliding window and one expander round.

module sha_message_expander_round (
  input  logic [15:0][31:0] history,
  output logic [31:0]       w
);
  logic [31:0] x0;
  logic [31:0] x1;
  logic [31:0] sig0;
  logic [31:0] sig1;

  // history[15] = W_t (oldest), so w = W_{t+16}
  always_comb begin
    x0   = history[14];
    x1   = history[1];
    sig0 = {x0[6:0], x0[31:7]} ^ {x0[17:0], x0[31:18]} ^ (x0 >> 3);
    sig1 = {x1[16:0], x1[31:17]} ^ {x1[18:0], x1[31:19]} ^ (x1 >> 10);
    w    = sig1 + history[6] + sig0 + history[15];
  end
endmodule

module sha_schedule_sequencer #(
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  sha_schedule_sequencer_if.slave  bus
);
  localparam int unsigned TW     = 6;
  localparam int unsigned NWORDS = 16;
  localparam logic [TW-1:0] T_LAST   = TW'(ROUNDS - 1);
  localparam logic [TW-1:0] T_PENULT = TW'(ROUNDS - 2);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                          state_q, state_d;
  logic [NWORDS-1:0][WIDTH-1:0]    hist_q, hist_d;
  logic [TW-1:0]                   t_q, t_d;
  logic                            blk_ready_q, blk_ready_d;
  logic                            w_valid_q, w_valid_d;
  logic                            busy_q, busy_d;
  logic                            last_q, last_d;
  logic [WIDTH-1:0]                w_new;
  logic                            xfer;

  sha_message_expander_round u_round (
    .history (hist_q),
    .w       (w_new)
  );

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    t_d         = t_q;
    blk_ready_d = blk_ready_q;
    w_valid_d   = w_valid_q;
    busy_d      = busy_q;
    last_d      = last_q;
    xfer        = w_valid_q & bus.w_ready_i;

    case (state_q)
      IDLE: begin
        if (bus.blk_valid_i) begin
          // M_0 lands in the oldest slot so it is presented first
          for (int unsigned j = 0; j < NWORDS; j++) begin
            hist_d[4'(NWORDS - 1 - j)] = bus.blk_i[4'(j)];
          end
          t_d         = '0;
          state_d     = RUN;
          blk_ready_d = 1'b0;
          w_valid_d   = 1'b1;
          busy_d      = 1'b1;
          last_d      = 1'b0;
        end
      end
      RUN: begin
        if (xfer) begin
          hist_d = {hist_q[NWORDS-2:0], w_new};
          t_d    = t_q + TW'(1);
          last_d = (t_q == T_PENULT);
          if (t_q == T_LAST) begin
            state_d     = IDLE;
            t_d         = '0;
            blk_ready_d = 1'b1;
            w_valid_d   = 1'b0;
            busy_d      = 1'b0;
            last_d      = 1'b0;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        blk_ready_d = 1'b1;
        w_valid_d   = 1'b0;
        busy_d      = 1'b0;
        last_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hist_q      <= '0;
      t_q         <= '0;
      blk_ready_q <= 1'b1;
      w_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      t_q         <= t_d;
      blk_ready_q <= blk_ready_d;
      w_valid_q   <= w_valid_d;
      busy_q      <= busy_d;
      last_q      <= last_d;
    end
  end

  assign bus.blk_ready_o = blk_ready_q;
  assign bus.w_valid_o   = w_valid_q;
  assign bus.w_o         = hist_q[NWORDS-1];
  assign bus.t_o         = t_q;
  assign bus.last_o      = last_q;
  assign bus.busy_o      = busy_q;
endmodule

// File: tb/tb_sha_schedule_sequencer.sv
// Scoreboard bench for sha_schedule_sequencer: directed blocks, backpressure,
// back-to-back, mid-block abort and reset/accept collision.
module tb_sha_schedule_sequencer;
  typedef logic [15:0][31:0] blk_t;
  typedef struct packed {
    logic [31:0] w;
    logic [5:0]  t;
    logic        last;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   mode;      // 0: model only, 1: "abc" hand values, 2: all-ones hand values
  logic bp_en;
  logic stall_q;
  logic [31:0] st_w;
  logic [5:0]  st_t;
  exp_t sb[$];

  sha_schedule_sequencer_if bus ();

  sha_schedule_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule computed with the textbook W[t-2], W[t-7], W[t-15], W[t-16] form
  task automatic push_block(input blk_t b);
    logic [31:0] w [64];
    exp_t e;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = b[t];
      else w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
                  (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      e.w    = w[t];
      e.t    = 6'(t);
      e.last = (t == 63);
      sb.push_back(e);
    end
  endtask

  task automatic issue_block(input blk_t b, output int acc);
    push_block(b);
    bus.blk_i       = b;
    bus.blk_valid_i = 1'b1;
    acc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.blk_ready_o) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got no blk_ready expected accept");
    end
  endtask

  task automatic wait_idle(output int done);
    done = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.blk_ready_o) begin
        done = cyc;
        break;
      end
    end
    check("idle_reached", 64'(done >= 0), 64'(1));
    check("queue_drained", 64'(sb.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  always begin
    @(posedge clk);
    #1;
    bus.w_ready_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on each transfer and checks handshake invariants
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_valid", 64'(bus.w_valid_o), 64'(1));
        check("stall_w", 64'(bus.w_o), 64'(st_w));
        check("stall_t", 64'(bus.t_o), 64'(st_t));
      end
      if (bus.w_valid_o) begin
        check("blk_ready_in_run", 64'(bus.blk_ready_o), 64'(0));
        check("busy_in_run", 64'(bus.busy_o), 64'(1));
      end
      if (bus.w_valid_o && bus.w_ready_i) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got t=%0d w=0x%0h expected none", bus.t_o, bus.w_o);
        end else begin
          e = sb.pop_front();
          check($sformatf("t_index_%0d", e.t), 64'(bus.t_o), 64'(e.t));
          check($sformatf("w_%0d", e.t), 64'(bus.w_o), 64'(e.w));
          check($sformatf("last_%0d", e.t), 64'(bus.last_o), 64'(e.last));
          if (mode == 1) begin
            case (bus.t_o)
              6'd0:  check("abc_w0", 64'(bus.w_o), 64'h6162_6380);
              6'd15: check("abc_w15", 64'(bus.w_o), 64'h0000_0018);
              6'd16: check("abc_w16", 64'(bus.w_o), 64'h6162_6380);
              6'd17: check("abc_w17", 64'(bus.w_o), 64'h000F_0000);
              6'd63: check("abc_w63", 64'(bus.w_o), 64'h12B1_EDEB);
              default: if (bus.t_o < 6'd15) check("abc_wzero", 64'(bus.w_o), 64'h0);
            endcase
          end else if (mode == 2) begin
            if (bus.t_o == 6'd16) check("ones_w16", 64'(bus.w_o), 64'h203F_FFFC);
            if (bus.t_o == 6'd17) check("ones_w17", 64'(bus.w_o), 64'h203F_FFFC);
          end
        end
      end
      stall_q = bus.w_valid_o && !bus.w_ready_i;
      st_w    = bus.w_o;
      st_t    = bus.t_o;
    end
  end

  initial begin
    blk_t abc, ones, blk_a, blk_b;
    int k1, k2, done;
    logic hit;
    n_tests = 0;
    n_fail  = 0;
    mode    = 0;
    bp_en   = 1'b0;
    stall_q = 1'b0;
    rst     = 1'b1;
    bus.blk_valid_i = 1'b0;
    bus.blk_i       = '0;
    bus.w_ready_i   = 1'b1;

    abc = '0;
    abc[0]  = 32'h6162_6380;
    abc[15] = 32'h0000_0018;
    ones = '1;
    for (int j = 0; j < 16; j++) begin
      blk_a[j] = 32'h0101_0101 * 32'(j + 1);
      blk_b[j] = 32'hDEAD_0000 ^ 32'(j * 7);
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst_blk_ready", 64'(bus.blk_ready_o), 64'(1));
    check("rst_w_valid", 64'(bus.w_valid_o), 64'(0));
    check("rst_busy", 64'(bus.busy_o), 64'(0));
    check("rst_t", 64'(bus.t_o), 64'(0));
    check("rst_last", 64'(bus.last_o), 64'(0));
    check("rst_w", 64'(bus.w_o), 64'(0));
    rst = 1'b0;

    // "abc" block at full rate, end-of-block timing
    mode = 1;
    issue_block(abc, k1);
    bus.blk_valid_i = 1'b0;
    wait_idle(done);
    check("abc_ready_cycle", 64'(done), 64'(k1 + 64));

    // same block with random backpressure
    bp_en = 1'b1;
    issue_block(abc, k1);
    bus.blk_valid_i = 1'b0;
    wait_idle(done);
    bp_en = 1'b0;

    // back-to-back blocks with blk_valid_i held high
    mode = 0;
    issue_block(blk_a, k1);
    issue_block(blk_b, k2);
    bus.blk_valid_i = 1'b0;
    check("b2b_accept_cycle", 64'(k2), 64'(k1 + 65));
    wait_idle(done);

    // reset while t=20 is on the bus
    mode = 1;
    issue_block(abc, k1);
    bus.blk_valid_i = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.w_valid_o && bus.t_o == 6'd20) begin
        hit = 1'b1;
        break;
      end
    end
    check("abort_reached_t20", 64'(hit), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    check("abort_w_valid", 64'(bus.w_valid_o), 64'(0));
    check("abort_blk_ready", 64'(bus.blk_ready_o), 64'(1));
    check("abort_t", 64'(bus.t_o), 64'(0));
    check("abort_w", 64'(bus.w_o), 64'(0));
    check("abort_busy", 64'(bus.busy_o), 64'(0));
    issue_block(abc, k1);
    bus.blk_valid_i = 1'b0;
    wait_idle(done);

    // reset wins over a simultaneous block offer
    rst = 1'b1;
    bus.blk_i = abc;
    bus.blk_valid_i = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.blk_valid_i = 1'b0;
    check("rstacc_w_valid", 64'(bus.w_valid_o), 64'(0));
    check("rstacc_blk_ready", 64'(bus.blk_ready_o), 64'(1));
    check("rstacc_busy", 64'(bus.busy_o), 64'(0));
    @(negedge clk);
    check("rstacc_w_valid_later", 64'(bus.w_valid_o), 64'(0));
    @(posedge clk);
    #1;

    // all-ones block exercises mod-2^32 wrap
    mode = 2;
    issue_block(ones, k1);
    bus.blk_valid_i = 1'b0;
    wait_idle(done);

    check("final_queue_empty", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
